// File: rtl/weight_row_feeder.sv
// weight_row_feeder: preloads NUM_ROWS x ROW_LEN weight words from a host, then streams one row per consumer request.
// Ports:
//   clk, reset          - single rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data      - host preload write strobe and word (ignored once loaded)
//   loaded              - all NUM_ROWS*ROW_LEN words are written
//   load_next_row       - consumer request level; a rising edge asks for the next row
//   weight, weight_valid- registered streamed word and its qualifier (weight holds when not valid)
//   row_done, all_done  - pulses with the last word of a row / of the final row
//   row_idx             - row being or next to be streamed
//   req_drop            - pulse one cycle after a request edge that could not be accepted
module weight_row_feeder #(
    parameter int DATA_W   = 16,
    parameter int ROW_LEN  = 8,
    parameter int NUM_ROWS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        loaded,
    input  logic                        load_next_row,
    output logic [DATA_W-1:0]           weight,
    output logic                        weight_valid,
    output logic                        row_done,
    output logic [$clog2(NUM_ROWS)-1:0] row_idx,
    output logic                        all_done,
    output logic                        req_drop
);
    localparam int TOTAL = NUM_ROWS * ROW_LEN;
    localparam int AW    = $clog2(TOTAL);
    localparam int CW    = $clog2(ROW_LEN);
    localparam int RW    = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {LOAD, READY, STREAM} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [TOTAL];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_addr;
    logic [CW-1:0]     col;
    logic              req_q;
    logic              req_edge;
    logic              wr_go;
    logic              last_wr;
    logic              last_col;

    assign req_edge = load_next_row & ~req_q;
    assign wr_go    = wr_en && state == LOAD;
    assign last_wr  = wr_go && wr_ptr == AW'(TOTAL - 1);
    assign last_col = state == STREAM && col == CW'(ROW_LEN - 1);
    assign rd_addr  = AW'(row_idx) * AW'(ROW_LEN) + AW'(col);
    assign loaded   = state != LOAD;

    // A request edge is only taken in READY; the row_done edge still sees STREAM, so it drops.
    always_comb begin
        state_nx = last_wr                        ? READY  :
                   (state == READY && req_edge)   ? STREAM :
                   last_col                       ? READY  : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // Weight storage is deliberately not reset; a full reload follows every reset.
    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            col          <= '0;
            req_q        <= 1'b0;
            row_idx      <= '0;
            weight       <= '0;
            weight_valid <= 1'b0;
            row_done     <= 1'b0;
            all_done     <= 1'b0;
            req_drop     <= 1'b0;
        end else begin
            req_q        <= load_next_row;
            req_drop     <= req_edge && state != READY;
            weight_valid <= state == STREAM;
            row_done     <= last_col;
            all_done     <= last_col && row_idx == RW'(NUM_ROWS - 1);
            if (wr_go) wr_ptr <= wr_ptr + 1'b1;
            if (state == STREAM) begin
                weight <= mem[rd_addr];
                col    <= last_col ? '0 : col + 1'b1;
                if (last_col) row_idx <= row_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_weight_row_feeder.sv
// tb_weight_row_feeder: table, directed corner sequences and random traffic against a word-queue reference model.
module tb_weight_row_feeder;
    localparam int DW  = 16;
    localparam int RL  = 8;
    localparam int NR  = 4;
    localparam int TOT = RL * NR;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          loaded;
    logic          load_next_row;
    logic [DW-1:0] weight;
    logic          weight_valid;
    logic          row_done;
    logic [1:0]    row_idx;
    logic          all_done;
    logic          req_drop;

    int compared   = 0;
    int mismatched = 0;

    weight_row_feeder #(.DATA_W(DW), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .loaded(loaded),
        .load_next_row(load_next_row), .weight(weight), .weight_valid(weight_valid),
        .row_done(row_done), .row_idx(row_idx), .all_done(all_done), .req_drop(req_drop)
    );

    always #5 clk = ~clk;

    // Reference model: words written so far, words still owed to the consumer, current row.
    logic [DW-1:0] m_mem [TOT];
    int            m_n, m_left, m_row;
    bit            m_prev, m_valid, m_done, m_all, m_drop;
    logic [DW-1:0] m_w;

    int            cnt_valid, cnt_drop;
    logic [DW-1:0] last_all_w;

    typedef struct {
        logic          lnr;
        logic          valid;
        logic [DW-1:0] w;
        logic          done;
        logic [1:0]    idx;
    } vec_t;
    vec_t tbl[10];

    task automatic m_reset();
        m_n = 0; m_left = 0; m_row = 0; m_prev = 0;
        m_valid = 0; m_done = 0; m_all = 0; m_drop = 0; m_w = '0;
    endtask

    task automatic m_edge();
        bit req, rdy;
        req    = load_next_row && !m_prev;
        m_prev = load_next_row;
        rdy    = m_n == TOT && m_left == 0;
        m_drop = req && !rdy;
        m_done = 0; m_all = 0;
        m_valid = m_left > 0;
        if (m_left > 0) begin
            m_w = m_mem[m_row * RL + RL - m_left];
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_all  = m_row == NR - 1;
                m_row  = (m_row + 1) % NR;
            end
        end else if (req && rdy) m_left = RL;
        if (wr_en && m_n < TOT) begin
            m_mem[m_n] = wr_data;
            m_n++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk("loaded", 32'(loaded), 32'(m_n == TOT));
        chk("weight_valid", 32'(weight_valid), 32'(m_valid));
        chk("weight", 32'(weight), 32'(m_w));
        chk("row_done", 32'(row_done), 32'(m_done));
        chk("all_done", 32'(all_done), 32'(m_all));
        chk("req_drop", 32'(req_drop), 32'(m_drop));
        chk("row_idx", 32'(row_idx), 32'(m_row));
        cnt_valid += int'(weight_valid);
        cnt_drop  += int'(req_drop);
        if (all_done) last_all_w = weight;
    endtask

    task automatic do_reset();
        wr_en = 0; load_next_row = 0; wr_data = '0;
        reset = 1;
        #1;
        chk("rst_weight", 32'(weight), 0);
        chk("rst_valid", 32'(weight_valid), 0);
        chk("rst_row_done", 32'(row_done), 0);
        chk("rst_all_done", 32'(all_done), 0);
        chk("rst_req_drop", 32'(req_drop), 0);
        chk("rst_row_idx", 32'(row_idx), 0);
        chk("rst_loaded", 32'(loaded), 0);
        m_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic write_words(input int first, input int count, input logic [DW-1:0] base);
        for (int i = first; i < first + count; i++) begin
            wr_en = 1; wr_data = base + DW'(i);
            step();
        end
        wr_en = 0;
    endtask

    task automatic run_row();
        load_next_row = 1; step();
        load_next_row = 0;
        repeat (RL) step();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 2'd0};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{k <= 1, 1'b1, 16'(16'h0100 + k - 1), k == 8, 2'(k == 8)};
        tbl[9] = '{1'b0, 1'b0, 16'h0107, 1'b0, 2'd1};

        do_reset();

        write_words(0, 10, 16'h0100);
        load_next_row = 1; step();
        chk("drop_in_load", 32'(req_drop), 1);
        load_next_row = 0; step();
        write_words(10, TOT - 10, 16'h0100);
        chk("loaded_after_32", 32'(loaded), 1);
        wr_en = 1; wr_data = 16'hDEAD; step();
        wr_en = 0;

        foreach (tbl[i]) begin
            load_next_row = tbl[i].lnr;
            step();
            chk("tbl_valid", 32'(weight_valid), 32'(tbl[i].valid));
            chk("tbl_weight", 32'(weight), 32'(tbl[i].w));
            chk("tbl_row_done", 32'(row_done), 32'(tbl[i].done));
            chk("tbl_row_idx", 32'(row_idx), 32'(tbl[i].idx));
        end

        last_all_w = '0;
        for (int r = 1; r < NR; r++) run_row();
        chk("all_done_word", 32'(last_all_w), 32'h011F);
        chk("row_idx_wrap", 32'(row_idx), 0);
        run_row();
        chk("rerun_row0_last", 32'(weight), 32'h0107);

        cnt_valid = 0; cnt_drop = 0;
        load_next_row = 1; step();
        load_next_row = 0; repeat (3) step();
        load_next_row = 1; step();
        load_next_row = 0; repeat (3) step();
        load_next_row = 1; step();
        load_next_row = 0; step();
        chk("mid_row_drops", 32'(cnt_drop), 2);
        chk("mid_row_valids", 32'(cnt_valid), RL);

        cnt_valid = 0;
        load_next_row = 1; repeat (30) step();
        load_next_row = 0; repeat (3) step();
        chk("held_level_one_row", 32'(cnt_valid), RL);

        load_next_row = 1; step();
        load_next_row = 0; repeat (5) step();
        chk("col4_valid_before_reset", 32'(weight_valid), 1);
        do_reset();
        cnt_valid = 0; cnt_drop = 0;
        load_next_row = 1; step();
        load_next_row = 0; step();
        write_words(0, TOT, 16'h0200);
        chk("post_reset_drop", 32'(cnt_drop), 1);
        chk("post_reset_no_valid", 32'(cnt_valid), 0);
        run_row();
        chk("reload_row0_last", 32'(weight), 32'h0207);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            wr_en   = $urandom_range(0, 3) != 0;
            wr_data = DW'($urandom);
            if ($urandom_range(0, 4) == 0) load_next_row = ~load_next_row;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
